operand_loader: RTL and testbench

- Upstream feeder for the approximate-multiplier datapath.
- Accepts 16-bit operands over a valid/ready stream and writes them into the 16x16 input RAM through its write port.
- Operands are written in pairs: even address = operand A, odd address = operand B.
- When a batch is complete, pulses start to the multiplier controller and holds off new input until the controller reports done.

---
 rtl/operand_loader_if.sv | 33 +++
 rtl/operand_loader.sv | 170 +++++++++++++++++
 tb/tb_operand_loader.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_loader_if.sv
// ----------------------------------------------------------------------------
// operand_loader_if
//   Operand stream into the operand loader.
//
//   Handshake: a word transfers on every rising clk edge where in_valid and
//   in_ready are both high. The source holds in_data stable while in_valid is
//   high and the word has not yet transferred. in_valid must not depend on
//   in_ready. in_ready may change in any cycle.
//
//   Signals:
//     in_data   operand word           (master -> slave)
//     in_valid  in_data is valid       (master -> slave)
//     in_ready  slave accepts a word   (slave  -> master)
// ----------------------------------------------------------------------------
interface operand_loader_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/operand_loader.sv
// ----------------------------------------------------------------------------
// operand_loader
//   Upstream feeder for the approximate-multiplier datapath. Collects 16-bit
//   operands from a valid/ready stream and writes them into the input RAM in
//   pairs (even address = operand A, odd address = operand B). When the RAM
//   is full, or a flush arrives with at least one word stored, an odd batch
//   is padded with a zero word, start is pulsed to the multiplier controller,
//   and input is held off until the controller returns done_i.
//
//   Optional feature (macro OPERAND_ZERO_FLAG_EN):
//     defined   -> zero_seen is a sticky flag set the cycle after any accepted
//                  word equal to zero (pad words excluded), cleared on done_i
//                  or reset.
//     undefined -> zero_seen is tied to 0.
//
//   Ports:
//     clk          rising-edge clock
//     rst          asynchronous, active-low reset
//     in_s         operand stream (operand_loader_if.slave)
//     flush        single-cycle request to launch a partial batch
//     wr_en        input RAM write enable (one-cycle pulse per write)
//     wr_addr      input RAM write address
//     wr_data      input RAM write data
//     start        one-cycle pulse: batch is ready in RAM
//     batch_pairs  operand pairs in the launched batch, held until done_i
//     done_i       one-cycle pulse from the controller: batch consumed
//     busy         high while launching or waiting for the controller
//     zero_seen    zero operand seen in this batch (see above)
//     dbg_state    current FSM state (0 FILL, 1 PAD_CHK, 2 LAUNCH, 3 WAIT)
// ----------------------------------------------------------------------------
module operand_loader #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    operand_loader_if.slave   in_s,
    input  logic              flush,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              start,
    output logic [ADDR_W-1:0] batch_pairs,
    input  logic              done_i,
    output logic              busy,
    output logic              zero_seen,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        PAD_CHK = 2'd1,
        LAUNCH  = 2'd2,
        WAIT    = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   count_inc;
    logic              wr_en_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [DATA_W-1:0] wr_data_d;
    logic              start_d;
    logic [ADDR_W-1:0] pairs_d;
    logic              hs;

    // Ready is gated by rst so it stays low while reset is held and rises
    // combinationally as soon as reset is released.
    assign in_s.in_ready = rst && (state_q == FILL) && (count_q < DEPTH_C);
    assign hs            = in_s.in_valid && in_s.in_ready;
    assign count_inc     = count_q + 1'b1;
    assign busy          = (state_q == LAUNCH) || (state_q == WAIT);
    assign dbg_state     = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FILL;
            count_q     <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            start       <= 1'b0;
            batch_pairs <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            wr_en       <= wr_en_d;
            wr_addr     <= wr_addr_d;
            wr_data     <= wr_data_d;
            start       <= start_d;
            batch_pairs <= pairs_d;
        end
    end

    // All outputs are registered: a write decided in FILL/PAD_CHK appears the
    // cycle after, and start is decided in LAUNCH so it lands the cycle after
    // LAUNCH, i.e. strictly after any pad write issued from PAD_CHK.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr;
        wr_data_d = wr_data;
        start_d   = 1'b0;
        pairs_d   = batch_pairs;

        case (state_q)
            FILL: begin
                if (hs) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = count_q[ADDR_W-1:0];
                    wr_data_d = in_s.in_data;
                    count_d   = count_inc;
                end
                // A flush in the same cycle as a handshake sees the updated
                // count, so a flush on the first word still launches.
                if ((count_d == DEPTH_C) || (flush && (count_d != '0))) begin
                    state_d = PAD_CHK;
                end
            end
            PAD_CHK: begin
                if (count_q[0]) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = count_q[ADDR_W-1:0];
                    wr_data_d = '0;
                    count_d   = count_inc;
                end
                // Padded count is even; pairs = count/2 (DEPTH gives DEPTH/2).
                pairs_d = count_d[ADDR_W:1];
                state_d = LAUNCH;
            end
            LAUNCH: begin
                start_d = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (done_i) begin
                    count_d = '0;
                    state_d = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

`ifdef OPERAND_ZERO_FLAG_EN
    logic zero_q;

    // Only stream handshakes feed the flag, so pad words never set it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            zero_q <= 1'b0;
        end else if ((state_q == WAIT) && done_i) begin
            zero_q <= 1'b0;
        end else if (hs && (in_s.in_data == '0)) begin
            zero_q <= 1'b1;
        end
    end

    assign zero_seen = zero_q;
`else
    assign zero_seen = 1'b0;
`endif

endmodule

// File: tb/tb_operand_loader.sv
// ----------------------------------------------------------------------------
// tb_operand_loader
//   Directed batches plus a randomized phase for operand_loader. A reference
//   model in the negedge compare process tracks each batch as "words
//   accepted so far" plus the cycle the batch closed, and derives every
//   expected output from those timestamps.
// ----------------------------------------------------------------------------
module tb_operand_loader;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int WQ     = 32 + ADDR_W + DATA_W;

`ifdef OPERAND_ZERO_FLAG_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    operand_loader_if #(.DATA_W(DATA_W)) lif ();

    logic              flush  = 1'b0;
    logic              done_i = 1'b0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              start;
    logic [ADDR_W-1:0] batch_pairs;
    logic              busy;
    logic              zero_seen;
    logic [1:0]        dbg_state;

    operand_loader #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_s        (lif),
        .flush       (flush),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .start       (start),
        .batch_pairs (batch_pairs),
        .done_i      (done_i),
        .busy        (busy),
        .zero_seen   (zero_seen),
        .dbg_state   (dbg_state)
    );

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model + compare ----------------
    logic [WQ-1:0] exp_q[$];   // {cycle, addr, data} of each expected write
    int            cyc       = 0;
    int            close_cyc = -1;  // cycle in which the current batch closed
    int            n_acc     = 0;   // words accepted into the current batch
    int            zero_from = -1;  // first cycle zero_seen must be high
    int            exp_pairs = 0;

    // Observations used by the directed literal checks.
    int                n_writes     = 0;
    int                n_starts     = 0;
    logic [ADDR_W-1:0] last_wr_addr = '0;
    logic [DATA_W-1:0] last_wr_data = '0;
    logic [ADDR_W-1:0] start_pairs  = '0;

    always @(negedge clk) begin
        bit            e_ready, e_busy, e_start, e_wr, e_zero;
        logic [WQ-1:0] front;
        if (!rst) begin
            chk("rst_in_ready", 32'(lif.in_ready), 0);
            chk("rst_wr_en", 32'(wr_en), 0);
            chk("rst_wr_addr", 32'(wr_addr), 0);
            chk("rst_wr_data", 32'(wr_data), 0);
            chk("rst_start", 32'(start), 0);
            chk("rst_pairs", 32'(batch_pairs), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_zero", 32'(zero_seen), 0);
            exp_q.delete();
            close_cyc = -1;
            n_acc     = 0;
            zero_from = -1;
        end else begin
            e_ready = (close_cyc < 0);
            e_busy  = (close_cyc >= 0) && (cyc >= close_cyc + 2);
            e_start = (close_cyc >= 0) && (cyc == close_cyc + 3);
            e_zero  = ZF && (zero_from >= 0) && (cyc >= zero_from);
            e_wr    = 1'b0;
            front   = '0;
            if (exp_q.size() > 0 && int'(exp_q[0][WQ-1 -: 32]) == cyc) begin
                e_wr  = 1'b1;
                front = exp_q.pop_front();
            end

            chk("in_ready", 32'(lif.in_ready), 32'(e_ready));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("start", 32'(start), 32'(e_start));
            chk("zero_seen", 32'(zero_seen), 32'(e_zero));
            chk("wr_en", 32'(wr_en), 32'(e_wr));
            if (e_wr) begin
                chk("wr_addr", 32'(wr_addr), 32'(front[DATA_W +: ADDR_W]));
                chk("wr_data", 32'(wr_data), 32'(front[DATA_W-1:0]));
            end
            if (e_busy) chk("batch_pairs", 32'(batch_pairs), 32'(exp_pairs));

            if (wr_en) begin
                n_writes++;
                last_wr_addr = wr_addr;
                last_wr_data = wr_data;
            end
            if (start) begin
                n_starts++;
                start_pairs = batch_pairs;
            end

            // Advance the model with this cycle's inputs.
            if (close_cyc < 0) begin
                if (lif.in_valid) begin
                    exp_q.push_back({32'(cyc + 1), 4'(n_acc), lif.in_data});
                    if (lif.in_data == '0 && zero_from < 0) zero_from = cyc + 1;
                    n_acc++;
                end
                if (n_acc == DEPTH || (flush && n_acc > 0)) begin
                    close_cyc = cyc;
                    exp_pairs = (n_acc + 1) / 2;
                    if (n_acc % 2 == 1) exp_q.push_back({32'(cyc + 2), 4'(n_acc), 16'h0000});
                end
            end else if (cyc >= close_cyc + 3 && done_i) begin
                close_cyc = -1;
                n_acc     = 0;
                zero_from = -1;
            end
        end
        cyc++;
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers one word (optionally with flush) until it transfers; leaves
    // in_valid high so consecutive calls form a back-to-back stream.
    task automatic send_word(input logic [DATA_W-1:0] d, input logic fl);
        bit got;
        int t;
        got = 1'b0;
        t   = 0;
        lif.in_valid = 1'b1;
        lif.in_data  = d;
        flush        = fl;
        while (!got && t < 50) begin
            got = lif.in_ready;
            step();
            t++;
        end
        flush = 1'b0;
        if (!got) chk("handshake_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        lif.in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic pulse_flush();
        lif.in_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic wait_start(input int s0);
        int t;
        t = 0;
        while (n_starts == s0 && t < 20) begin
            step();
            t++;
        end
        chk("start_seen", 32'(n_starts > s0), 1);
    endtask

    task automatic pulse_done();
        done_i = 1'b1;
        step();
        done_i = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int s0;
        int w0;
        lif.in_valid = 1'b0;
        lif.in_data  = '0;

        // Reset held: every output at its reset value.
        repeat (3) step();
        chk("lit_rst_in_ready", 32'(lif.in_ready), 0);
        chk("lit_rst_pairs", 32'(batch_pairs), 0);
        rst = 1'b1;
        step();
        chk("lit_ready_after_rst", 32'(lif.in_ready), 1);

        // Full batch 0x0001..0x0010, valid held high.
        s0 = n_starts;
        w0 = n_writes;
        for (int i = 1; i <= DEPTH; i++) send_word(16'(i), 1'b0);
        lif.in_valid = 1'b0;
        chk("lit_full_ready_low", 32'(lif.in_ready), 0);
        wait_start(s0);
        chk("lit_full_writes", 32'(n_writes - w0), 16);
        chk("lit_full_last_addr", 32'(last_wr_addr), 15);
        chk("lit_full_last_data", 32'(last_wr_data), 16);
        chk("lit_full_pairs", 32'(start_pairs), 8);
        chk("lit_full_busy", 32'(busy), 1);

        // Backpressure: valid high through WAIT, then done_i.
        lif.in_valid = 1'b1;
        lif.in_data  = 16'h5555;
        repeat (10) step();
        chk("lit_bp_one_start", 32'(n_starts - s0), 1);
        pulse_done();
        send_word(16'h5555, 1'b0);
        idle(1);
        chk("lit_bp_addr0", 32'(last_wr_addr), 0);
        chk("lit_bp_data", 32'(last_wr_data), 32'h5555);
        s0 = n_starts;
        pulse_flush();
        wait_start(s0);
        chk("lit_bp_pairs", 32'(start_pairs), 1);
        pulse_done();

        // Odd flush: 5 words, pad at addr 5, 3 pairs.
        s0 = n_starts;
        for (int i = 1; i <= 5; i++) send_word(16'hA000 + 16'(i), 1'b0);
        pulse_flush();
        wait_start(s0);
        chk("lit_odd_pad_addr", 32'(last_wr_addr), 5);
        chk("lit_odd_pad_data", 32'(last_wr_data), 0);
        chk("lit_odd_pairs", 32'(start_pairs), 3);
        pulse_done();

        // Flush with an empty batch is ignored.
        s0 = n_starts;
        idle(2);
        pulse_flush();
        idle(4);
        chk("lit_empty_flush_no_start", 32'(n_starts - s0), 0);
        chk("lit_empty_flush_fill", 32'(dbg_state), 0);

        // Flush on the 4th handshake: 4 words, no pad, 2 pairs.
        for (int i = 1; i <= 3; i++) send_word(16'hC000 + 16'(i), 1'b0);
        send_word(16'hC004, 1'b1);
        lif.in_valid = 1'b0;
        wait_start(s0);
        chk("lit_f4_last_addr", 32'(last_wr_addr), 3);
        chk("lit_f4_last_data", 32'(last_wr_data), 32'hC004);
        chk("lit_f4_pairs", 32'(start_pairs), 2);
        pulse_done();

        // Zero operand at position 3.
        s0 = n_starts;
        send_word(16'h1111, 1'b0);
        send_word(16'h2222, 1'b0);
        send_word(16'h3333, 1'b0);
        chk("lit_zero_before", 32'(zero_seen), 0);
        send_word(16'h0000, 1'b0);
        chk("lit_zero_set", 32'(zero_seen), 32'(ZF));
        for (int i = 0; i < 4; i++) send_word(16'h7000 + 16'(i), 1'b0);
        pulse_flush();
        wait_start(s0);
        chk("lit_zero_held", 32'(zero_seen), 32'(ZF));
        pulse_done();
        chk("lit_zero_cleared", 32'(zero_seen), 0);

        // Odd flush whose only zero is the pad.
        s0 = n_starts;
        for (int i = 1; i <= 3; i++) send_word(16'h0F00 + 16'(i), 1'b0);
        pulse_flush();
        wait_start(s0);
        chk("lit_pad_no_zero", 32'(zero_seen), 0);
        pulse_done();

        // Reset mid-fill, asserted between clock edges.
        for (int i = 1; i <= 7; i++) send_word(16'hD000 + 16'(i), 1'b0);
        lif.in_valid = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("lit_async_wr_en", 32'(wr_en), 0);
        chk("lit_async_wr_addr", 32'(wr_addr), 0);
        chk("lit_async_wr_data", 32'(wr_data), 0);
        chk("lit_async_in_ready", 32'(lif.in_ready), 0);
        chk("lit_async_pairs", 32'(batch_pairs), 0);
        @(posedge clk);
        #2 rst = 1'b1;
        step();
        s0 = n_starts;
        send_word(16'hBEEF, 1'b0);
        idle(1);
        chk("lit_rst_next_addr", 32'(last_wr_addr), 0);
        chk("lit_rst_next_data", 32'(last_wr_data), 32'hBEEF);
        pulse_flush();
        wait_start(s0);
        pulse_done();

        // Randomized phase: the compare process checks every cycle.
        for (int i = 0; i < 800; i++) begin
            lif.in_valid = ($urandom_range(0, 3) != 0);
            lif.in_data  = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
            flush        = ($urandom_range(0, 11) == 0);
            done_i       = ($urandom_range(0, 3) == 0);
            step();
        end
        lif.in_valid = 1'b0;
        flush        = 1'b0;
        done_i       = 1'b0;
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
